spram_arbiter_ctrl: RTL and testbench

- Shares one 16x8 single-port synchronous RAM between two requesters, A and B, using round-robin arbitration.
- Also contains a clear sequencer that fills every RAM entry with a constant value while requesters are locked out.
- Sits directly in front of the RAM port and drives its we/addr/din lines; it takes the RAM's dout as input.
- RAM contract: one operation per clk. A write leaves dout unchanged. A read updates dout one clk after the operation is presented.

---
 rtl/spram_arbiter_ctrl.sv | 159 +++++++++++++++
 tb/tb_spram_arbiter_ctrl.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spram_arbiter_ctrl.sv
// Round-robin arbiter for two requesters sharing one single-port sync RAM, plus a fill-clear sequencer.
// Optional macro SPRAM_ARB_FIXED_PRI_EN: fixed priority (A always wins), no round-robin pointer.
module spram_arbiter_ctrl #(
   parameter int unsigned    DW         = 8,
   parameter int unsigned    AW         = 4,
   parameter int unsigned    DEPTH      = 16,
   parameter int unsigned    RAM_AW     = 8,
   parameter logic [DW-1:0]  FILL_VALUE = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_a,
   input  logic              we_a,
   input  logic [AW-1:0]     addr_a,
   input  logic [DW-1:0]     din_a,
   output logic              gnt_a,
   output logic              rvalid_a,
   output logic [DW-1:0]     rdata_a,
   input  logic              req_b,
   input  logic              we_b,
   input  logic [AW-1:0]     addr_b,
   input  logic [DW-1:0]     din_b,
   output logic              gnt_b,
   output logic              rvalid_b,
   output logic [DW-1:0]     rdata_b,
   input  logic              clr_start,
   output logic              busy,
   output logic              clr_done,
   output logic              ram_we,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [DW-1:0]     ram_din,
   input  logic [DW-1:0]     ram_dout
);

   typedef enum logic [0:0] {StArb, StClear} state_e;

   state_e             state_q, state_d;
   logic [AW-1:0]      cnt_q, cnt_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               ram_we_q, ram_we_d;
   logic [RAM_AW-1:0]  ram_addr_q, ram_addr_d;
   logic [DW-1:0]      ram_din_q, ram_din_d;
   logic               v1_q, v2_q, tag1_q, tag2_q;
   logic               rvalid_a_q, rvalid_b_q;
   logic [DW-1:0]      rdata_a_q, rdata_b_q;
   logic               prio_a;

`ifdef SPRAM_ARB_FIXED_PRI_EN
   assign prio_a = 1'b1;
`else
   // Set when B was granted last; reset value makes A win the first contention.
   logic last_b_q;
   assign prio_a = last_b_q;

   always_ff @(posedge clk) begin
      if (rst)        last_b_q <= 1'b1;
      else if (gnt_a) last_b_q <= 1'b0;
      else if (gnt_b) last_b_q <= 1'b1;
   end
`endif

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      ram_we_d   = 1'b0;
      ram_addr_d = ram_addr_q;
      ram_din_d  = ram_din_q;
      gnt_a      = 1'b0;
      gnt_b      = 1'b0;
      unique case (state_q)
         StArb: begin
            if (done_q) busy_d = 1'b0;
            // busy_q is still high during the clr_done clk, which blocks grants there.
            if (!busy_q && !rst) begin
               if (clr_start) begin
                  state_d = StClear;
                  busy_d  = 1'b1;
                  cnt_d   = '0;
               end else begin
                  gnt_a = req_a && (!req_b || prio_a);
                  gnt_b = req_b && !gnt_a;
                  if (gnt_a) begin
                     ram_we_d   = we_a;
                     ram_addr_d = RAM_AW'(addr_a);
                     ram_din_d  = din_a;
                  end else if (gnt_b) begin
                     ram_we_d   = we_b;
                     ram_addr_d = RAM_AW'(addr_b);
                     ram_din_d  = din_b;
                  end
               end
            end
         end
         StClear: begin
            ram_we_d   = 1'b1;
            ram_addr_d = RAM_AW'(cnt_q);
            ram_din_d  = FILL_VALUE;
            cnt_d      = cnt_q + 1'b1;
            if (cnt_q == AW'(DEPTH - 1)) begin
               state_d = StArb;
               done_d  = 1'b1;
               cnt_d   = '0;
            end
         end
         default: state_d = StArb;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StArb;
         cnt_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         ram_we_q   <= 1'b0;
         ram_addr_q <= '0;
         ram_din_q  <= '0;
         v1_q       <= 1'b0;
         v2_q       <= 1'b0;
         tag1_q     <= 1'b0;
         tag2_q     <= 1'b0;
         rvalid_a_q <= 1'b0;
         rvalid_b_q <= 1'b0;
         rdata_a_q  <= '0;
         rdata_b_q  <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         ram_we_q   <= ram_we_d;
         ram_addr_q <= ram_addr_d;
         ram_din_q  <= ram_din_d;
         // Read-return pipeline: tag 1 marks an access owned by B.
         v1_q       <= (gnt_a && !we_a) || (gnt_b && !we_b);
         tag1_q     <= gnt_b;
         v2_q       <= v1_q;
         tag2_q     <= tag1_q;
         rvalid_a_q <= v2_q && !tag2_q;
         rvalid_b_q <= v2_q && tag2_q;
         if (v2_q && !tag2_q) rdata_a_q <= ram_dout;
         if (v2_q && tag2_q)  rdata_b_q <= ram_dout;
      end
   end

   assign busy     = busy_q;
   assign clr_done = done_q;
   assign ram_we   = ram_we_q;
   assign ram_addr = ram_addr_q;
   assign ram_din  = ram_din_q;
   assign rvalid_a = rvalid_a_q;
   assign rvalid_b = rvalid_b_q;
   assign rdata_a  = rdata_a_q;
   assign rdata_b  = rdata_b_q;

endmodule

// File: tb/tb_spram_arbiter_ctrl.sv
// Directed bench for spram_arbiter_ctrl with a behavioural 16x8 single-port RAM attached.
module tb_spram_arbiter_ctrl;

   logic       clk;
   logic       rst;
   logic       req_a, we_a, gnt_a, rvalid_a;
   logic [3:0] addr_a;
   logic [7:0] din_a, rdata_a;
   logic       req_b, we_b, gnt_b, rvalid_b;
   logic [3:0] addr_b;
   logic [7:0] din_b, rdata_b;
   logic       clr_start, busy, clr_done;
   logic       ram_we;
   logic [7:0] ram_addr, ram_din, ram_dout;
   logic [7:0] mem [16];

   int checks;
   int failures;

   spram_arbiter_ctrl dut (
      .clk(clk), .rst(rst),
      .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a),
      .gnt_a(gnt_a), .rvalid_a(rvalid_a), .rdata_a(rdata_a),
      .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b),
      .gnt_b(gnt_b), .rvalid_b(rvalid_b), .rdata_b(rdata_b),
      .clr_start(clr_start), .busy(busy), .clr_done(clr_done),
      .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) begin
      if (ram_we) mem[ram_addr[3:0]] <= ram_din;
      else        ram_dout <= mem[ram_addr[3:0]];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Hold one request until granted, then drop it; returns one clk after the grant.
   task automatic access(input bit sel_b, input bit wr, input logic [3:0] a, input logic [7:0] d);
      int   n;
      logic g;
      n = 0;
      g = 1'b0;
      if (sel_b) begin req_b = 1'b1; we_b = wr; addr_b = a; din_b = d; end
      else       begin req_a = 1'b1; we_a = wr; addr_a = a; din_a = d; end
      while (g !== 1'b1 && n < 50) begin
         @(negedge clk);
         g = sel_b ? gnt_b : gnt_a;
         tick();
         n++;
      end
      req_a = 1'b0; we_a = 1'b0; req_b = 1'b0; we_b = 1'b0;
      checks++;
      if (g !== 1'b1) begin
         failures++;
         $display("FAIL access_grant: no grant after %0d clks, required one (sel_b=%0b addr=%0d)",
                  n, sel_b, a);
      end
   endtask

   task automatic rd(input bit sel_b, input logic [3:0] a, output logic [7:0] data,
                     output logic vld);
      access(sel_b, 1'b0, a, 8'h00);
      tick();
      tick();
      @(negedge clk);
      vld  = sel_b ? rvalid_b : rvalid_a;
      data = sel_b ? rdata_b : rdata_a;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req_a = 0; we_a = 0; addr_a = 0; din_a = 0;
      req_b = 0; we_b = 0; addr_b = 0; din_b = 0;
      clr_start = 0;
      tick();
      tick();
      @(negedge clk);
      checks++;
      if ({gnt_a, gnt_b, rvalid_a, rvalid_b, busy, clr_done, ram_we} !== 7'b0) begin
         failures++;
         $display("FAIL reset_flags: got %b required 0000000",
                  {gnt_a, gnt_b, rvalid_a, rvalid_b, busy, clr_done, ram_we});
      end
      checks++;
      if ({ram_addr, ram_din} !== 16'h0) begin
         failures++;
         $display("FAIL reset_ram_bus: addr=%h din=%h required 00/00", ram_addr, ram_din);
      end
      checks++;
      if ({rdata_a, rdata_b} !== 16'h0) begin
         failures++;
         $display("FAIL reset_rdata: a=%h b=%h required 00/00", rdata_a, rdata_b);
      end
      tick();
      rst = 1'b0;
   endtask

   task automatic test_single();
      req_a = 1; we_a = 1; addr_a = 4'd3; din_a = 8'hA5;
      @(negedge clk);
      checks++;
      if (gnt_a !== 1'b1) begin
         failures++; $display("FAIL single_wr_gnt: gnt_a=%b required 1", gnt_a);
      end
      tick();
      req_a = 0; we_a = 0;
      @(negedge clk);
      checks++;
      if ({ram_we, ram_addr, ram_din} !== {1'b1, 8'h03, 8'hA5}) begin
         failures++;
         $display("FAIL single_wr_bus: we=%b addr=%h din=%h required 1/03/a5",
                  ram_we, ram_addr, ram_din);
      end
      tick();
      req_a = 1; we_a = 0; addr_a = 4'd3;
      @(negedge clk);
      checks++;
      if (gnt_a !== 1'b1) begin
         failures++; $display("FAIL single_rd_gnt: gnt_a=%b required 1", gnt_a);
      end
      tick();
      req_a = 0;
      @(negedge clk);
      checks++;
      if ({ram_we, ram_addr} !== {1'b0, 8'h03}) begin
         failures++;
         $display("FAIL single_rd_bus: we=%b addr=%h required 0/03", ram_we, ram_addr);
      end
      tick();
      @(negedge clk);
      checks++;
      if (rvalid_a !== 1'b0) begin
         failures++; $display("FAIL single_rd_early: rvalid_a=%b required 0", rvalid_a);
      end
      tick();
      @(negedge clk);
      checks++;
      if ({rvalid_a, rdata_a} !== {1'b1, 8'hA5}) begin
         failures++;
         $display("FAIL single_rd_data: rvalid_a=%b rdata_a=%h required 1/a5", rvalid_a, rdata_a);
      end
      tick();
      @(negedge clk);
      checks++;
      if ({rvalid_a, rdata_a} !== {1'b0, 8'hA5}) begin
         failures++;
         $display("FAIL single_rd_hold: rvalid_a=%b rdata_a=%h required 0/a5", rvalid_a, rdata_a);
      end
      tick();
   endtask

   task automatic test_contention();
      bit         exp_b [8];
      logic [7:0] exp_d [8];
      int         na, nb, ia, ib, j;
      logic       ok;
      for (int i = 0; i < 4; i++) access(1'b0, 1'b1, 4'(i), 8'(8'h10 + i));
      for (int i = 0; i < 4; i++) access(1'b1, 1'b1, 4'(4 + i), 8'(8'h20 + i));
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      na = 0;
      nb = 0;
      for (int k = 0; k < 8; k++) begin
`ifdef SPRAM_ARB_FIXED_PRI_EN
         exp_b[k] = (k >= 4);
`else
         exp_b[k] = ((k % 2) == 1);
`endif
         if (exp_b[k]) begin exp_d[k] = 8'(8'h20 + nb); nb++; end
         else          begin exp_d[k] = 8'(8'h10 + na); na++; end
      end
      ia = 0;
      ib = 0;
      for (int k = 0; k < 12; k++) begin
         req_a = (ia < 4); we_a = 0; addr_a = 4'(ia);
         req_b = (ib < 4); we_b = 0; addr_b = 4'(4 + ib);
         @(negedge clk);
         if (k < 8) begin
            checks++;
            if ({gnt_a, gnt_b} !== {!exp_b[k], exp_b[k]}) begin
               failures++;
               $display("FAIL contention_gnt[%0d]: gnt_a/b=%b%b required %b%b",
                        k, gnt_a, gnt_b, !exp_b[k], exp_b[k]);
            end
         end
         if (k >= 3 && k < 11) begin
            j = k - 3;
            if (exp_b[j]) ok = (rvalid_b === 1'b1) && (rvalid_a === 1'b0) && (rdata_b === exp_d[j]);
            else          ok = (rvalid_a === 1'b1) && (rvalid_b === 1'b0) && (rdata_a === exp_d[j]);
            checks++;
            if (!ok) begin
               failures++;
               $display("FAIL contention_rdata[%0d]: rv_a=%b rd_a=%h rv_b=%b rd_b=%h required %s %h",
                        j, rvalid_a, rdata_a, rvalid_b, rdata_b, exp_b[j] ? "B" : "A", exp_d[j]);
            end
         end
         if (gnt_a === 1'b1) ia++;
         if (gnt_b === 1'b1) ib++;
         tick();
      end
      req_a = 0;
      req_b = 0;
   endtask

   task automatic test_back_to_back();
      int ib;
      for (int i = 0; i < 16; i++) access(1'b1, 1'b1, 4'(i), 8'(i * 2));
      ib = 0;
      for (int k = 0; k < 20; k++) begin
         req_b = (ib < 16); we_b = 0; addr_b = 4'(ib);
         @(negedge clk);
         if (k < 16) begin
            checks++;
            if (gnt_b !== 1'b1) begin
               failures++; $display("FAIL b2b_gnt[%0d]: gnt_b=%b required 1", k, gnt_b);
            end
         end
         if (k >= 3 && k < 19) begin
            checks++;
            if ({rvalid_b, rdata_b} !== {1'b1, 8'(2 * (k - 3))}) begin
               failures++;
               $display("FAIL b2b_rdata[%0d]: rvalid_b=%b rdata_b=%h required 1/%h",
                        k - 3, rvalid_b, rdata_b, 8'(2 * (k - 3)));
            end
         end
         if (gnt_b === 1'b1) ib++;
         tick();
      end
      req_b = 0;
   endtask

   task automatic test_clear();
      int busy_n, done_n, done_at, gnt_at, bad;
      for (int i = 0; i < 16; i++) access(1'b0, 1'b1, 4'(i), 8'hFF);
      clr_start = 1; req_a = 1; we_a = 0; addr_a = 4'd9;
      @(negedge clk);
      checks++;
      if ({gnt_a, busy} !== 2'b00) begin
         failures++; $display("FAIL clear_start_cycle: gnt_a=%b busy=%b required 0/0", gnt_a, busy);
      end
      tick();
      clr_start = 0;
      busy_n = 0; done_n = 0; done_at = -1; gnt_at = -1; bad = 0;
      for (int k = 1; k < 40 && gnt_at < 0; k++) begin
         @(negedge clk);
         if (busy === 1'b1) begin
            busy_n++;
            if (gnt_a !== 1'b0 || gnt_b !== 1'b0) bad++;
         end
         if (clr_done === 1'b1) begin done_n++; done_at = k; end
         if (gnt_a === 1'b1) gnt_at = k;
         tick();
      end
      req_a = 0;
      checks++;
      if (busy_n !== 17) begin
         failures++; $display("FAIL clear_busy_len: busy clks=%0d required 17", busy_n);
      end
      checks++;
      if (done_n !== 1 || done_at !== 17) begin
         failures++;
         $display("FAIL clear_done: pulses=%0d at clk %0d required 1 at 17", done_n, done_at);
      end
      checks++;
      if (bad !== 0 || gnt_at !== 18) begin
         failures++;
         $display("FAIL clear_gnt: grants during busy=%0d first gnt_a at %0d required 0 and 18",
                  bad, gnt_at);
      end
      tick();
      tick();
      @(negedge clk);
      checks++;
      if ({rvalid_a, rdata_a} !== {1'b1, 8'h00}) begin
         failures++;
         $display("FAIL clear_read9: rvalid_a=%b rdata_a=%h required 1/00", rvalid_a, rdata_a);
      end
      tick();
   endtask

   task automatic test_reset_mid_clear();
      logic [7:0] d;
      logic       v;
      bit         saw_done, saw_busy;
      access(1'b0, 1'b1, 4'd10, 8'h5A);
      clr_start = 1;
      tick();
      clr_start = 0;
      repeat (5) tick();
      @(negedge clk);
      checks++;
      if ({busy, ram_we, ram_addr} !== {1'b1, 1'b1, 8'h04}) begin
         failures++;
         $display("FAIL midclr_progress: busy=%b we=%b addr=%h required 1/1/04",
                  busy, ram_we, ram_addr);
      end
      tick();
      rst = 1;
      tick();
      rst = 0;
      @(negedge clk);
      checks++;
      if ({gnt_a, gnt_b, rvalid_a, rvalid_b, busy, clr_done, ram_we, ram_addr, ram_din,
           rdata_a, rdata_b} !== 39'h0) begin
         failures++;
         $display("FAIL midclr_reset: busy=%b done=%b we=%b addr=%h din=%h rd_a=%h rd_b=%h required all 0",
                  busy, clr_done, ram_we, ram_addr, ram_din, rdata_a, rdata_b);
      end
      saw_done = 0;
      saw_busy = 0;
      for (int k = 0; k < 25; k++) begin
         tick();
         @(negedge clk);
         if (clr_done === 1'b1) saw_done = 1;
         if (busy === 1'b1) saw_busy = 1;
      end
      tick();
      checks++;
      if (saw_done || saw_busy) begin
         failures++;
         $display("FAIL midclr_no_done: clr_done seen=%0b busy seen=%0b required 0/0",
                  saw_done, saw_busy);
      end
      rd(1'b0, 4'd10, d, v);
      checks++;
      if ({v, d} !== {1'b1, 8'h5A}) begin
         failures++; $display("FAIL midclr_read10: rvalid=%b rdata=%h required 1/5a", v, d);
      end
   endtask

`ifdef SPRAM_ARB_FIXED_PRI_EN
   task automatic test_fixed_pri();
      req_a = 1; we_a = 0; addr_a = 4'd0;
      req_b = 1; we_b = 0; addr_b = 4'd1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checks++;
         if ({gnt_a, gnt_b} !== 2'b10) begin
            failures++;
            $display("FAIL fixed_pri[%0d]: gnt_a/b=%b%b required 10", k, gnt_a, gnt_b);
         end
         tick();
      end
      req_a = 0;
      req_b = 0;
      repeat (4) tick();
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      checks = 0;
      failures = 0;
      test_reset();
      test_single();
      test_contention();
      test_back_to_back();
      test_clear();
      test_reset_mid_clear();
`ifdef SPRAM_ARB_FIXED_PRI_EN
      test_fixed_pri();
`endif
      repeat (3) tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
